// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU operand sequencer: FSM state encoding and logic-unit opcodes.
package alu_seq_pkg;

  localparam int unsigned WIDTH_DEF = 8;
  localparam int unsigned OP_W      = 3;
  localparam int unsigned ST_W      = 3;

  typedef enum logic [2:0] {
    LOAD_A  = 3'd0,
    LOAD_B  = 3'd1,
    LOAD_OP = 3'd2,
    EXEC    = 3'd3,
    SHOW    = 3'd4
  } seq_state_e;

  localparam logic [OP_W-1:0] OP_AND = 3'b000;
  localparam logic [OP_W-1:0] OP_OR  = 3'b001;
  localparam logic [OP_W-1:0] OP_XOR = 3'b010;
  localparam logic [OP_W-1:0] OP_NOT = 3'b011;
  localparam logic [OP_W-1:0] OP_SHL = 3'b100;
  localparam logic [OP_W-1:0] OP_SHR = 3'b101;

endpackage

// File: rtl/detector_flanco.sv
// Rising-edge detector: one-cycle pulse when sig_i goes high, held level counts once.
module detector_flanco (
  input  logic clk,
  input  logic rst,
  input  logic sig_i,
  output logic pulse_c
);

  logic prev_q;

  always_ff @(posedge clk) begin
    if (rst) prev_q <= 1'b0;
    else     prev_q <= sig_i;
  end

  assign pulse_c = sig_i & ~prev_q;

endmodule

// File: rtl/alu_operand_sequencer.sv
// Loads A, B and opcode from a shared switch bus on button presses, drives the logic unit
// and captures its result. Define ALU_SEQ_FLAGS_EN to generate the zero/negative flag registers.
module alu_operand_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] dato_in,
  input  logic [2:0]       control_in,
  input  logic             boton,
  input  logic [WIDTH-1:0] resultado,
  output logic [WIDTH-1:0] numero1,
  output logic [WIDTH-1:0] numero2,
  output logic [2:0]       ALUControl,
  output logic [WIDTH-1:0] result_q,
  output logic             flag_z,
  output logic             flag_n,
  output logic             valid,
  output logic [2:0]       estado
);

  seq_state_e       state_q;
  logic [WIDTH-1:0] num1_q;
  logic [WIDTH-1:0] num2_q;
  logic [OP_W-1:0]  op_q;
  logic [WIDTH-1:0] res_q;
  logic             valid_q;
  logic             press_c;

  detector_flanco u_det (
    .clk     (clk),
    .rst     (rst),
    .sig_i   (boton),
    .pulse_c (press_c)
  );

  // Sequencer: one load per press, EXEC always lasts exactly one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD_A;
      num1_q  <= '0;
      num2_q  <= '0;
      op_q    <= '0;
      res_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        LOAD_A: begin
          if (press_c) begin
            num1_q  <= dato_in;
            valid_q <= 1'b0;
            state_q <= LOAD_B;
          end
        end
        LOAD_B: begin
          if (press_c) begin
            num2_q  <= dato_in;
            state_q <= LOAD_OP;
          end
        end
        LOAD_OP: begin
          if (press_c) begin
            op_q    <= control_in;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          res_q   <= resultado;
          valid_q <= 1'b1;
          state_q <= SHOW;
        end
        SHOW: begin
          // A press here starts the next round, so it also loads operand A
          if (press_c) begin
            num1_q  <= dato_in;
            valid_q <= 1'b0;
            state_q <= LOAD_B;
          end
        end
        default: begin
          valid_q <= 1'b0;
          state_q <= LOAD_A;
        end
      endcase
    end
  end

`ifdef ALU_SEQ_FLAGS_EN
  logic flag_z_q;
  logic flag_n_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      flag_z_q <= 1'b0;
      flag_n_q <= 1'b0;
    end else if (state_q == EXEC) begin
      flag_z_q <= (resultado == '0);
      flag_n_q <= resultado[WIDTH-1];
    end
  end

  assign flag_z = flag_z_q;
  assign flag_n = flag_n_q;
`else
  assign flag_z = 1'b0;
  assign flag_n = 1'b0;
`endif

  assign numero1    = num1_q;
  assign numero2    = num2_q;
  assign ALUControl = op_q;
  assign result_q   = res_q;
  assign valid      = valid_q;
  assign estado     = ST_W'(state_q);

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed bench for alu_operand_sequencer with a behavioural logic unit closing the loop.
module tb_alu_operand_sequencer;
  import alu_seq_pkg::*;

`ifdef ALU_SEQ_FLAGS_EN
  localparam bit FE = 1'b1;
`else
  localparam bit FE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] dato_in;
  logic [2:0] control_in;
  logic       boton;
  logic [7:0] resultado;
  logic [7:0] numero1;
  logic [7:0] numero2;
  logic [2:0] ALUControl;
  logic [7:0] result_q;
  logic       flag_z;
  logic       flag_n;
  logic       valid;
  logic [2:0] estado;

  int nvec = 0;
  int nerr = 0;

  alu_operand_sequencer #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .dato_in    (dato_in),
    .control_in (control_in),
    .boton      (boton),
    .resultado  (resultado),
    .numero1    (numero1),
    .numero2    (numero2),
    .ALUControl (ALUControl),
    .result_q   (result_q),
    .flag_z     (flag_z),
    .flag_n     (flag_n),
    .valid      (valid),
    .estado     (estado)
  );

  // Logic unit downstream of the sequencer
  always_comb begin
    resultado = numero2;
    case (ALUControl)
      OP_AND:  resultado = numero1 & numero2;
      OP_OR:   resultado = numero1 | numero2;
      OP_XOR:  resultado = numero1 ^ numero2;
      OP_NOT:  resultado = ~numero1;
      OP_SHL:  resultado = numero1 << 1;
      OP_SHR:  resultado = numero1 >> 1;
      default: resultado = numero2;
    endcase
  end

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [7:0] d, input logic [2:0] c);
    dato_in    = d;
    control_in = c;
    boton      = 1'b1;
    tick();
    boton      = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " numero1"}, numero1, 8'h00);
    chk({tag, " numero2"}, numero2, 8'h00);
    chk({tag, " ALUControl"}, 8'(ALUControl), 8'h00);
    chk({tag, " result_q"}, result_q, 8'h00);
    chk({tag, " flag_z"}, 8'(flag_z), 8'h00);
    chk({tag, " flag_n"}, 8'(flag_n), 8'h00);
    chk({tag, " valid"}, 8'(valid), 8'h00);
    chk({tag, " estado"}, 8'(estado), 8'h00);
  endtask

  // Full A / B / opcode round; works from LOAD_A or SHOW
  task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic [2:0] op, input logic [7:0] exp_res,
                       input logic z, input logic n);
    press(a, 3'b111);
    chk({tag, " A estado"}, 8'(estado), 8'd1);
    chk({tag, " A numero1"}, numero1, a);
    chk({tag, " A valid"}, 8'(valid), 8'h00);
    tick();
    press(b, 3'b111);
    chk({tag, " B estado"}, 8'(estado), 8'd2);
    chk({tag, " B numero2"}, numero2, b);
    tick();
    press(8'hFF, op);
    chk({tag, " OP estado"}, 8'(estado), 8'd3);
    chk({tag, " OP ALUControl"}, 8'(ALUControl), 8'(op));
    chk({tag, " OP valid"}, 8'(valid), 8'h00);
    tick();
    chk({tag, " SHOW estado"}, 8'(estado), 8'd4);
    chk({tag, " SHOW valid"}, 8'(valid), 8'h01);
    chk({tag, " SHOW result"}, result_q, exp_res);
    chk({tag, " SHOW flag_z"}, 8'(flag_z), 8'(FE & z));
    chk({tag, " SHOW flag_n"}, 8'(flag_n), 8'(FE & n));
    tick();
    chk({tag, " hold estado"}, 8'(estado), 8'd4);
    chk({tag, " hold result"}, result_q, exp_res);
    chk({tag, " hold numero1"}, numero1, a);
  endtask

  initial begin
    rst        = 1'b1;
    boton      = 1'b0;
    dato_in    = 8'h00;
    control_in = 3'b000;
    tick();
    tick();
    rst = 1'b0;
    check_all_zero("reset");
    tick();
    chk("idle estado", 8'(estado), 8'd0);

    do_op("and",  8'hE5, 8'hAB, 3'b000, 8'hA1, 1'b0, 1'b1);
    do_op("or",   8'hE5, 8'hAB, 3'b001, 8'hEF, 1'b0, 1'b1);
    do_op("xor",  8'hE5, 8'hAB, 3'b010, 8'h4E, 1'b0, 1'b0);
    do_op("not",  8'hE5, 8'hAB, 3'b011, 8'h1A, 1'b0, 1'b0);
    do_op("zero", 8'h0F, 8'hF0, 3'b000, 8'h00, 1'b1, 1'b0);
    do_op("shl",  8'h3C, 8'h00, 3'b100, 8'h78, 1'b0, 1'b0);
    do_op("shr",  8'hE5, 8'h00, 3'b101, 8'h72, 1'b0, 1'b0);
    do_op("op7",  8'h12, 8'h80, 3'b111, 8'h80, 1'b0, 1'b1);

    // Reset while parked in LOAD_OP with both operands loaded
    press(8'h11, 3'b000);
    tick();
    press(8'h22, 3'b000);
    tick();
    chk("pre-rst estado", 8'(estado), 8'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_all_zero("rst in LOAD_OP");

    // Button held for 20 cycles counts as one press
    dato_in = 8'h5A;
    boton   = 1'b1;
    tick();
    chk("held first estado", 8'(estado), 8'd1);
    chk("held numero1", numero1, 8'h5A);
    dato_in = 8'h77;
    repeat (19) tick();
    chk("held end estado", 8'(estado), 8'd1);
    chk("held end numero1", numero1, 8'h5A);
    chk("held numero2", numero2, 8'h00);
    boton = 1'b0;
    tick();

    // Opcode press held through EXEC and SHOW must not start a new round
    press(8'h0F, 3'b000);
    tick();
    dato_in    = 8'h99;
    control_in = 3'b001;
    boton      = 1'b1;
    tick();
    chk("hold-op estado", 8'(estado), 8'd3);
    tick();
    chk("hold-op show", 8'(estado), 8'd4);
    chk("hold-op result", result_q, 8'h5F);
    tick();
    tick();
    chk("hold-op stay", 8'(estado), 8'd4);
    chk("hold-op numero1", numero1, 8'h5A);
    chk("hold-op valid", 8'(valid), 8'h01);
    boton = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
